// File: rtl/pdp1_sb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdp1_sb_pkg                                                          |
// | Shared types and constants for the PDP-1 sequence-break controller:  |
// | FSM state encoding, break-cycle codes, default vector base and the   |
// | width of a channel index.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pdp1_sb_pkg;

  localparam int CHAN_W = 4;

  localparam logic [11:0] BRK_BASE_DEFAULT = 12'o0100;

  // Break-cycle codes as driven on {bc1, bc2}.
  localparam logic [1:0] BC_NONE = 2'b00;
  localparam logic [1:0] BC_1    = 2'b01;
  localparam logic [1:0] BC_2    = 2'b10;
  localparam logic [1:0] BC_3    = 2'b11;

  typedef enum logic [2:0] {
    SB_IDLE = 3'd0,
    SB_PEND = 3'd1,
    SB_BC1  = 3'd2,
    SB_BC2  = 3'd3,
    SB_BC3  = 3'd4
  } sb_state_e;

endpackage : pdp1_sb_pkg
`default_nettype wire

// File: rtl/pdp1_sb_prienc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdp1_sb_prienc                                                       |
// | Combinational find-first-set. Bit 0 is the highest priority.         |
// | Ports:                                                               |
// |   req   in  W       request vector                                   |
// |   valid out 1       any bit of req set                               |
// |   idx   out CHAN_W  index of the lowest set bit (0 when none)        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pdp1_sb_prienc
  import pdp1_sb_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]      req,
  output logic              valid,
  output logic [CHAN_W-1:0] idx
);

  // Scan from the lowest-priority end so the last hit is the winner.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = CHAN_W'(i);
      end
    end
  end

endmodule : pdp1_sb_prienc
`default_nettype wire

// File: rtl/pdp1_seqbrk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdp1_seqbrk                                                          |
// | PDP-1 sequence-break (interrupt) controller. Latches device break    |
// | requests, masks and prioritises them, raises brk_req at instruction  |
// | end and sequences the three break cycles (store AC, PC, IO+jump).    |
// |                                                                      |
// | Build option: macro PDP1_SBS16_EN selects the NCHAN-channel priority |
// | system; without it a single channel (0) collects all dev_req bits.   |
// |                                                                      |
// | Ports:                                                               |
// |   clk, reset          clock, asynchronous active-high reset          |
// |   dev_req[NCHAN]      asynchronous device request levels             |
// |   iot_esm/lsm         enter / leave sequence-break mode (lsm wins)   |
// |   iot_cbs             clear all held and active channels             |
// |   iot_asc/dsc/isb     enable / disable / software-break iot_chan     |
// |   inst_done, bc_step  CPU timing pulses (tp10)                       |
// |   dismiss             return from break: clear top active channel    |
// |   sbm, brk_req        mode flag, break pending to CPU                |
// |   bc1, bc2            cycle code {bc1,bc2}: 01 BC1, 10 BC2, 11 BC3   |
// |   brk_chan, brk_addr  serviced channel, break-cycle memory address   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pdp1_seqbrk
  import pdp1_sb_pkg::*;
#(
  parameter int          NCHAN    = 16,
  parameter logic [11:0] BRK_BASE = BRK_BASE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCHAN-1:0] dev_req,
  input  logic             iot_esm,
  input  logic             iot_lsm,
  input  logic             iot_cbs,
  input  logic             iot_asc,
  input  logic             iot_dsc,
  input  logic             iot_isb,
  input  logic [3:0]       iot_chan,
  input  logic             inst_done,
  input  logic             bc_step,
  input  logic             dismiss,
  output logic             sbm,
  output logic             brk_req,
  output logic             bc1,
  output logic             bc2,
  output logic [3:0]       brk_chan,
  output logic [11:0]      brk_addr
);

`ifdef PDP1_SBS16_EN
  localparam int NCH = NCHAN;
`else
  localparam int NCH = 1;
`endif

  logic [NCH-1:0]    req_in;
  logic [NCH-1:0]    sync1_q, sync1_d;
  logic [NCH-1:0]    sync2_q, sync2_d;
  logic [NCH-1:0]    prev_q, prev_d;
  logic [NCH-1:0]    held_q, held_d;
  logic [NCH-1:0]    active_q, active_d;
  logic [NCH-1:0]    en_vec;
  logic              sbm_q, sbm_d;
  sb_state_e         state_q, state_d;
  logic [CHAN_W-1:0] chan_q, chan_d;

  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    set_vec;
  logic [NCH-1:0]    hp_ok;
  logic [NCH-1:0]    eligible;
  logic [NCH-1:0]    chan_oh;
  logic [NCH-1:0]    dis_oh;
  logic              chan_elig;
  logic              seq_done;
  logic              grant_valid;
  logic [CHAN_W-1:0] grant_idx;
  logic              dis_valid;
  logic [CHAN_W-1:0] dis_idx;
  logic [1:0]        bc_off;

  // ------------------------------------------------------------------
  // Request input, enable mask and software-break set vector
  // ------------------------------------------------------------------
`ifdef PDP1_SBS16_EN
  logic [NCH-1:0] enable_q, enable_d;

  always_comb begin
    req_in   = dev_req;
    enable_d = enable_q;
    for (int i = 0; i < NCH; i++) begin
      // dsc is applied after asc so it wins on a shared channel.
      if (iot_asc && (iot_chan == CHAN_W'(i))) enable_d[i] = 1'b1;
      if (iot_dsc && (iot_chan == CHAN_W'(i))) enable_d[i] = 1'b0;
      set_vec[i] = rise[i] | (iot_isb & (iot_chan == CHAN_W'(i)));
    end
    en_vec = enable_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) enable_q <= '0;
    else       enable_q <= enable_d;
  end
`else
  logic unused_ok;

  // Single channel: every device shares channel 0, which is always enabled.
  // ORing before the synchroniser is safe because the result is a level.
  always_comb begin
    req_in    = |dev_req;
    en_vec    = '1;
    set_vec   = rise | iot_isb;
    unused_ok = ^{iot_asc, iot_dsc, iot_chan, BRK_BASE};
  end
`endif

  // ------------------------------------------------------------------
  // Synchroniser, edge detect, priority masking
  // ------------------------------------------------------------------
  always_comb begin
    logic acc;
    sync1_d = req_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;

    // A channel may break only if no active channel at or above its own
    // priority exists; this also blocks re-entry of an active channel.
    acc = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      acc      = acc | active_q[i];
      hp_ok[i] = ~acc;
      chan_oh[i] = (chan_q == CHAN_W'(i));
      dis_oh[i]  = (dis_idx == CHAN_W'(i));
    end
    eligible  = held_q & en_vec & {NCH{sbm_q}} & hp_ok;
    chan_elig = |(eligible & chan_oh);
  end

  pdp1_sb_prienc #(.W(NCH)) u_grant_enc (
    .req   (eligible),
    .valid (grant_valid),
    .idx   (grant_idx)
  );

  pdp1_sb_prienc #(.W(NCH)) u_dismiss_enc (
    .req   (active_q),
    .valid (dis_valid),
    .idx   (dis_idx)
  );

  // ------------------------------------------------------------------
  // Break FSM
  // ------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    seq_done = 1'b0;
    case (state_q)
      SB_IDLE: begin
        if (grant_valid) begin
          state_d = SB_PEND;
          chan_d  = grant_idx;
        end
      end
      SB_PEND: begin
        // Losing eligibility (lsm, cbs, dsc) withdraws the request even
        // if inst_done arrives in the same cycle.
        if (!chan_elig)     state_d = SB_IDLE;
        else if (inst_done) state_d = SB_BC1;
      end
      SB_BC1:  if (bc_step) state_d = SB_BC2;
      SB_BC2:  if (bc_step) state_d = SB_BC3;
      SB_BC3: begin
        if (bc_step) begin
          state_d  = SB_IDLE;
          seq_done = 1'b1;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Held / active / mode updates (later assignments take priority)
  // ------------------------------------------------------------------
  always_comb begin
    held_d = held_q;
    if (seq_done) held_d = held_d & ~chan_oh;
    held_d = held_d | set_vec;
    if (iot_cbs) held_d = '0;

    active_d = active_q;
    if (dismiss && dis_valid) active_d = active_d & ~dis_oh;
    if (seq_done)             active_d = active_d | chan_oh;
    if (iot_cbs)              active_d = '0;

    sbm_d = sbm_q;
    if (iot_esm) sbm_d = 1'b1;
    if (iot_lsm) sbm_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      held_q   <= '0;
      active_q <= '0;
      sbm_q    <= 1'b0;
      state_q  <= SB_IDLE;
      chan_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      held_q   <= held_d;
      active_q <= active_d;
      sbm_q    <= sbm_d;
      state_q  <= state_d;
      chan_q   <= chan_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  always_comb begin
    sbm      = sbm_q;
    brk_req  = (state_q == SB_PEND);
    brk_chan = chan_q;
    bc_off   = 2'd0;
    {bc1, bc2} = BC_NONE;
    case (state_q)
      SB_BC1: begin {bc1, bc2} = BC_1; bc_off = 2'd0; end
      SB_BC2: begin {bc1, bc2} = BC_2; bc_off = 2'd1; end
      SB_BC3: begin {bc1, bc2} = BC_3; bc_off = 2'd2; end
      default: ;
    endcase
    brk_addr = 12'd0;
    if ({bc1, bc2} != BC_NONE) begin
`ifdef PDP1_SBS16_EN
      brk_addr = BRK_BASE + 12'({chan_q, 2'b00}) + 12'(bc_off);
`else
      brk_addr = 12'(bc_off);
`endif
    end
  end

endmodule : pdp1_seqbrk
`default_nettype wire

// File: tb/tb_pdp1_seqbrk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pdp1_seqbrk                                                       |
// | Self-checking bench for pdp1_seqbrk: a per-cycle vector table        |
// | (inputs for one clock, expected outputs after that edge) plus a      |
// | hand-written reset-during-BC2 sequence. Covers both build options.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pdp1_seqbrk;

  localparam logic [5:0] K_ESM = 6'b100000;
  localparam logic [5:0] K_LSM = 6'b010000;
  localparam logic [5:0] K_CBS = 6'b001000;
  localparam logic [5:0] K_ASC = 6'b000100;
  localparam logic [5:0] K_DSC = 6'b000010;
  localparam logic [5:0] K_ISB = 6'b000001;
  localparam logic [2:0] K_IDN = 3'b100;
  localparam logic [2:0] K_BCS = 3'b010;
  localparam logic [2:0] K_DIS = 3'b001;

  typedef struct {
    logic [15:0] dev;
    logic [5:0]  ctl;
    logic [3:0]  chn;
    logic [2:0]  cyc;
    logic [19:0] exp;   // {sbm, brk_req, bc1, bc2, brk_chan, brk_addr}
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dev_req = '0;
  logic        iot_esm = 0, iot_lsm = 0, iot_cbs = 0;
  logic        iot_asc = 0, iot_dsc = 0, iot_isb = 0;
  logic [3:0]  iot_chan = '0;
  logic        inst_done = 0, bc_step = 0, dismiss = 0;
  logic        sbm, brk_req, bc1, bc2;
  logic [3:0]  brk_chan;
  logic [11:0] brk_addr;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  pdp1_seqbrk #(.NCHAN(16), .BRK_BASE(12'o0100)) dut (
    .clk(clk), .reset(reset), .dev_req(dev_req),
    .iot_esm(iot_esm), .iot_lsm(iot_lsm), .iot_cbs(iot_cbs),
    .iot_asc(iot_asc), .iot_dsc(iot_dsc), .iot_isb(iot_isb),
    .iot_chan(iot_chan), .inst_done(inst_done), .bc_step(bc_step),
    .dismiss(dismiss), .sbm(sbm), .brk_req(brk_req), .bc1(bc1), .bc2(bc2),
    .brk_chan(brk_chan), .brk_addr(brk_addr)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] dev, input logic [5:0] ctl,
                              input logic [3:0] chn, input logic [2:0] cyc,
                              input logic s, input logic r, input logic [1:0] bc,
                              input logic [3:0] ch, input logic [11:0] addr);
    vec_t v;
    v.dev = dev; v.ctl = ctl; v.chn = chn; v.cyc = cyc;
    v.exp = {s, r, bc, ch, addr};
    return v;
  endfunction

  task automatic check(input string name, input int step, input logic [19:0] want);
    logic [19:0] got;
    got = {sbm, brk_req, bc1, bc2, brk_chan, brk_addr};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got sbm=%b req=%b bc=%b chan=%0d addr=%o, want sbm=%b req=%b bc=%b chan=%0d addr=%o",
               name, step, got[19], got[18], got[17:16], got[15:12], got[11:0],
               want[19], want[18], want[17:16], want[15:12], want[11:0]);
    end
  endtask

  task automatic drive(input vec_t v);
    dev_req = v.dev;
    {iot_esm, iot_lsm, iot_cbs, iot_asc, iot_dsc, iot_isb} = v.ctl;
    iot_chan = v.chn;
    {inst_done, bc_step, dismiss} = v.cyc;
  endtask

  task automatic cycle(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] a_bc2;
    logic [15:0] d;

`ifdef PDP1_SBS16_EN
    // Three-level nesting, dismiss order, disabled channel, dsc-over-asc, cbs.
    vq.push_back(mk(16'h0000, K_ESM, 0, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(16'h0000, K_ASC, 3, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(16'h0000, K_ASC, 5, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(16'h0000, K_ASC, 2, 0, 1, 0, 2'b00, 0, 0));
    d = 16'h0008;
    for (int i = 0; i < 3; i++) vq.push_back(mk(d, 0, 0, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 1, 2'b00, 3, 0));
    vq.push_back(mk(d, 0, 0, K_IDN, 1, 0, 2'b01, 3, 12'o114));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b10, 3, 12'o115));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b11, 3, 12'o116));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b00, 3, 0));
    d = 16'h000C;   // ch2 rises while ch3 active: nested break
    for (int i = 0; i < 3; i++) vq.push_back(mk(d, 0, 0, 0, 1, 0, 2'b00, 3, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 1, 2'b00, 2, 0));
    vq.push_back(mk(d, 0, 0, K_IDN, 1, 0, 2'b01, 2, 12'o110));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b10, 2, 12'o111));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b11, 2, 12'o112));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b00, 2, 0));
    d = 16'h002C;   // ch5 rises, blocked by active 2 and 3
    for (int i = 0; i < 4; i++) vq.push_back(mk(d, 0, 0, 0, 1, 0, 2'b00, 2, 0));
    vq.push_back(mk(d, 0, 0, K_DIS, 1, 0, 2'b00, 2, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 0, 2'b00, 2, 0));
    vq.push_back(mk(d, 0, 0, K_DIS, 1, 0, 2'b00, 2, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 1, 2'b00, 5, 0));
    vq.push_back(mk(d, K_ASC | K_DSC, 5, 0, 1, 1, 2'b00, 5, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 0, 2'b00, 5, 0));
    vq.push_back(mk(d, K_ASC, 5, 0, 1, 0, 2'b00, 5, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 1, 2'b00, 5, 0));
    vq.push_back(mk(d, K_CBS, 0, 0, 1, 1, 2'b00, 5, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 0, 2'b00, 5, 0));
    d = 16'h003C;   // ch4 rises while disabled
    for (int i = 0; i < 4; i++) vq.push_back(mk(d, 0, 0, 0, 1, 0, 2'b00, 5, 0));
    vq.push_back(mk(d, K_ASC, 4, 0, 1, 0, 2'b00, 5, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 1, 2'b00, 4, 0));
    vq.push_back(mk(d, 0, 0, K_IDN, 1, 0, 2'b01, 4, 12'o120));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b10, 4, 12'o121));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b11, 4, 12'o122));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b00, 4, 0));
    a_bc2 = 12'o101;
`else
    // Single channel: dev_req[9] folds into channel 0.
    d = 16'h0200;
    vq.push_back(mk(16'h0000, K_ESM, 0, 0, 1, 0, 2'b00, 0, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(d, 0, 0, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(d, 0, 0, 0,     1, 1, 2'b00, 0, 0));
    vq.push_back(mk(d, 0, 0, K_IDN, 1, 0, 2'b01, 0, 0));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b10, 0, 1));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b11, 0, 2));
    vq.push_back(mk(d, 0, 0, K_BCS, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 0, 0,     1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, K_ASC | K_DSC, 9, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 0, 0,     1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, K_ISB, 0, 0, 1, 0, 2'b00, 0, 0));   // held, blocked by active
    vq.push_back(mk(0, 0, 0, 0,     1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 0, K_DIS, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 0, 0,     1, 1, 2'b00, 0, 0));
    vq.push_back(mk(0, K_LSM, 0, 0, 0, 1, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 0, 0,     0, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, K_ESM, 0, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 0, 0,     1, 1, 2'b00, 0, 0));
    vq.push_back(mk(0, K_LSM, 0, K_IDN, 0, 0, 2'b01, 0, 0));  // lsm cannot abort
    vq.push_back(mk(0, 0, 0, K_BCS, 0, 0, 2'b10, 0, 1));
    vq.push_back(mk(0, 0, 0, K_BCS, 0, 0, 2'b11, 0, 2));
    vq.push_back(mk(0, 0, 0, K_BCS, 0, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, K_ESM | K_LSM, 0, 0, 0, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, K_ESM, 0, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, K_ISB, 0, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, K_CBS, 0, 0, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 0, K_DIS, 1, 0, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 0, 0,     1, 0, 2'b00, 0, 0));
    a_bc2 = 12'd1;
`endif

    // Reset state
    #12;
    check("reset", 0, 20'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset", 0, 20'h0);

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i]);
      check("vec", i, vq[i].exp);
    end

    // Reset asserted while in BC2: outputs clear without a clock edge.
    d = vq[vq.size() - 1].dev;
    cycle(mk(d, K_ASC | K_ISB, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(d, 0, 0, 0, 0, 0, 0, 0, 0));
    check("seq_pend", 1, {1'b1, 1'b1, 2'b00, 4'd0, 12'd0});
    cycle(mk(d, 0, 0, K_IDN, 0, 0, 0, 0, 0));
    cycle(mk(d, 0, 0, K_BCS, 0, 0, 0, 0, 0));
    check("seq_bc2", 2, {1'b1, 1'b0, 2'b10, 4'd0, a_bc2});
    #1 reset = 1'b1;
    #1;
    check("reset_in_bc2", 3, 20'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(d, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("after_reset", 4, 20'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pdp1_seqbrk
`default_nettype wire
